// File: rtl/ether_cfg_sched.sv
// ether_cfg_sched
// Collects configuration frames carried in received Ethernet payloads,
// validates them, and hands the validated configuration to the renderer
// only on a vsync boundary, so the active configuration never changes
// mid-frame.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   frame_start  one-cycle pulse, first cycle of a received frame
//   word_valid   word_data valid this cycle
//   word_data    payload word (first word of a frame is the header)
//   frame_end    one-cycle pulse, frame finished
//   frame_ok     checksum verdict, sampled with frame_end
//   vsync        renderer frame boundary pulse
//   cfg_data     active configuration, word i at [32i+31:32i]
//   cfg_update   one-cycle pulse when cfg_data/cfg_seq were just loaded
//   cfg_seq      sequence byte of the active configuration
//   pending      a validated configuration is waiting for vsync
//   busy         frame parser not idle
//   good_cnt     accepted frames (saturating)
//   drop_cnt     rejected frames (saturating)
module ether_cfg_sched #(
    parameter int          NUM_WORDS = 8,
    parameter logic [15:0] MAGIC     = 16'hCAFE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    word_valid,
    input  logic [31:0]             word_data,
    input  logic                    frame_end,
    input  logic                    frame_ok,
    input  logic                    vsync,
    output logic [NUM_WORDS*32-1:0] cfg_data,
    output logic                    cfg_update,
    output logic [7:0]              cfg_seq,
    output logic                    pending,
    output logic                    busy,
    output logic [7:0]              good_cnt,
    output logic [7:0]              drop_cnt
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FLUSH} state_t;

    localparam logic [4:0] LAST = 5'(NUM_WORDS);

    state_t state, next_state;
    logic [4:0] idx, idx_next;
    logic write_en, latch_seq, accept, drop, overflow;

    logic [31:0]             staging [NUM_WORDS];
    logic [7:0]              stage_seq;
    logic [NUM_WORDS*32-1:0] staged_merged;
    logic [NUM_WORDS*32-1:0] pend_data;
    logic [7:0]              pend_seq;

    // Header bits [15:8] carry nothing this block uses.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^word_data[15:8];

    assign busy = (state != IDLE);

    // Frame parser: a word arriving with frame_end is processed first,
    // so acceptance sees the index after that word.
    always_comb begin
        next_state = state;
        idx_next   = idx;
        write_en   = 1'b0;
        latch_seq  = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        overflow   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) next_state = HEADER;
            end
            HEADER: begin
                if (frame_start) begin
                    drop       = 1'b1;
                    next_state = HEADER;
                end else begin
                    if (word_valid) begin
                        if (word_data[31:16] == MAGIC) begin
                            latch_seq  = 1'b1;
                            idx_next   = 5'd0;
                            next_state = PAYLOAD;
                        end else begin
                            next_state = FLUSH;
                        end
                    end
                    if (frame_end) begin
                        drop       = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (frame_start) begin
                    drop       = 1'b1;
                    next_state = HEADER;
                end else begin
                    if (word_valid) begin
                        if (idx == LAST) begin
                            overflow   = 1'b1;
                            next_state = FLUSH;
                        end else begin
                            write_en = 1'b1;
                            idx_next = idx + 5'd1;
                        end
                    end
                    if (frame_end) begin
                        if (!overflow && frame_ok && idx_next == LAST) accept = 1'b1;
                        else                                             drop   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (frame_start) begin
                    drop       = 1'b1;
                    next_state = HEADER;
                end else if (frame_end) begin
                    drop       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Staging view including a word written in this same cycle, so an
    // accepting frame_end coincident with the last word copies it too.
    always_comb begin
        staged_merged = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            staged_merged[32*i +: 32] = (write_en && idx == 5'(i)) ? word_data : staging[i];
        end
    end

    // Frame storage needs no reset; it is only observed after a write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (write_en && idx == 5'(i)) staging[i] <= word_data;
        end
        if (latch_seq) stage_seq <= word_data[7:0];
        if (accept) begin
            pend_data <= staged_merged;
            pend_seq  <= stage_seq;
        end
    end

    // Control, handoff and counters. A vsync commits the old pending set;
    // an acceptance in the same cycle re-arms pending for the next vsync.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 5'd0;
            pending    <= 1'b0;
            cfg_data   <= '0;
            cfg_seq    <= 8'd0;
            cfg_update <= 1'b0;
            good_cnt   <= 8'd0;
            drop_cnt   <= 8'd0;
        end else begin
            state      <= next_state;
            idx        <= idx_next;
            cfg_update <= 1'b0;
            if (vsync && pending) begin
                cfg_data   <= pend_data;
                cfg_seq    <= pend_seq;
                cfg_update <= 1'b1;
                pending    <= 1'b0;
            end
            if (accept) pending <= 1'b1;
            if (accept && good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
            if (drop && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ether_cfg_sched.sv
// tb_ether_cfg_sched
// Directed bench for ether_cfg_sched (NUM_WORDS=8, MAGIC=16'hCAFE).
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 time unit after the next rising edge.
module tb_ether_cfg_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         frame_start = 1'b0;
    logic         word_valid = 1'b0;
    logic [31:0]  word_data = 32'd0;
    logic         frame_end = 1'b0;
    logic         frame_ok = 1'b0;
    logic         vsync = 1'b0;
    logic [255:0] cfg_data;
    logic         cfg_update;
    logic [7:0]   cfg_seq;
    logic         pending;
    logic         busy;
    logic [7:0]   good_cnt;
    logic [7:0]   drop_cnt;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int upd_before;

    ether_cfg_sched dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .word_valid(word_valid), .word_data(word_data),
        .frame_end(frame_end), .frame_ok(frame_ok), .vsync(vsync),
        .cfg_data(cfg_data), .cfg_update(cfg_update), .cfg_seq(cfg_seq),
        .pending(pending), .busy(busy), .good_cnt(good_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Count update pulses mid-cycle so "exactly one update" can be checked.
    always @(negedge clk) begin
        if (cfg_update) upd_cnt <= upd_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle with the given inputs, then pulses return low.
    task automatic applyStimulus(input logic fs, input logic wv, input logic [31:0] wd,
                                 input logic fe, input logic fok, input logic vs);
        frame_start = fs; word_valid = wv; word_data = wd;
        frame_end = fe; frame_ok = fok; vsync = vs;
        @(posedge clk);
        #1;
        frame_start = 1'b0; word_valid = 1'b0; word_data = 32'd0;
        frame_end = 1'b0; frame_ok = 1'b0; vsync = 1'b0;
    endtask

    // Full frame: start, header, nwords words base+k, then frame_end.
    // merge_end puts frame_end on the last word; vs_end adds vsync to it.
    task automatic send_frame(input logic [31:0] hdr, input int nwords, input logic [31:0] base,
                              input logic ok, input logic merge_end, input logic vs_end);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, hdr, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < nwords; k++) begin
            if (merge_end && k == nwords - 1)
                applyStimulus(1'b0, 1'b1, base + 32'(k), 1'b1, ok, vs_end);
            else
                applyStimulus(1'b0, 1'b1, base + 32'(k), 1'b0, 1'b0, 1'b0);
        end
        if (!merge_end) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, ok, vs_end);
    endtask

    function automatic logic [255:0] exp_cfg(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cfg_data", cfg_data, 256'd0);
        checkOutput("rst_cfg_seq", 256'(cfg_seq), 256'd0);
        checkOutput("rst_update", 256'(cfg_update), 256'd0);
        checkOutput("rst_pending", 256'(pending), 256'd0);
        checkOutput("rst_busy", 256'(busy), 256'd0);
        checkOutput("rst_good", 256'(good_cnt), 256'd0);
        checkOutput("rst_drop", 256'(drop_cnt), 256'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Good frame seq 5, words 1..8
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_header", 256'(busy), 256'd1);
        applyStimulus(1'b0, 1'b1, 32'hCAFE_0005, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 32'(k + 1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("g1_pending", 256'(pending), 256'd1);
        checkOutput("g1_good", 256'(good_cnt), 256'd1);
        checkOutput("g1_busy", 256'(busy), 256'd0);
        checkOutput("g1_cfg_hold", cfg_data, 256'd0);
        upd_before = upd_cnt;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("g1_update", 256'(cfg_update), 256'd1);
        checkOutput("g1_cfg", cfg_data, exp_cfg(32'd1));
        checkOutput("g1_seq", 256'(cfg_seq), 256'd5);
        checkOutput("g1_pend_clr", 256'(pending), 256'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("g1_vsync_idle", 256'(cfg_update), 256'd0);
        checkOutput("g1_one_update", 256'(upd_cnt - upd_before), 256'd1);

        // Bad checksum, then short frame
        send_frame(32'hCAFE_0006, 8, 32'h100, 1'b0, 1'b0, 1'b0);
        send_frame(32'hCAFE_0007, 7, 32'h200, 1'b1, 1'b0, 1'b0);
        checkOutput("bad_drop", 256'(drop_cnt), 256'd2);
        checkOutput("bad_pending", 256'(pending), 256'd0);
        checkOutput("bad_good", 256'(good_cnt), 256'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("bad_no_update", 256'(cfg_update), 256'd0);
        checkOutput("bad_cfg_kept", cfg_data, exp_cfg(32'd1));

        // Two good frames before vsync; second ends on its last word
        upd_before = upd_cnt;
        send_frame(32'hCAFE_0001, 8, 32'h10, 1'b1, 1'b0, 1'b0);
        send_frame(32'hCAFE_0002, 8, 32'h20, 1'b1, 1'b1, 1'b0);
        checkOutput("two_good", 256'(good_cnt), 256'd3);
        checkOutput("two_pending", 256'(pending), 256'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("two_seq", 256'(cfg_seq), 256'd2);
        checkOutput("two_cfg", cfg_data, exp_cfg(32'h20));
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("two_one_update", 256'(upd_cnt - upd_before), 256'd1);

        // Acceptance of seq 3 coincident with vsync while seq 2 pending
        send_frame(32'hCAFE_0002, 8, 32'h40, 1'b1, 1'b0, 1'b0);
        send_frame(32'hCAFE_0003, 8, 32'h50, 1'b1, 1'b0, 1'b1);
        checkOutput("coin_update", 256'(cfg_update), 256'd1);
        checkOutput("coin_seq", 256'(cfg_seq), 256'd2);
        checkOutput("coin_cfg", cfg_data, exp_cfg(32'h40));
        checkOutput("coin_pending", 256'(pending), 256'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("coin_seq_next", 256'(cfg_seq), 256'd3);
        checkOutput("coin_cfg_next", cfg_data, exp_cfg(32'h50));
        checkOutput("coin_good", 256'(good_cnt), 256'd5);

        // IDLE ignores stray words and frame_end
        applyStimulus(1'b0, 1'b1, 32'hCAFE_0009, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_good", 256'(good_cnt), 256'd5);
        checkOutput("idle_drop", 256'(drop_cnt), 256'd2);

        // Bad magic, overflow, abort mid-payload (restart is a good frame)
        upd_before = upd_cnt;
        send_frame(32'hBEEF_0001, 8, 32'h300, 1'b1, 1'b0, 1'b0);
        send_frame(32'hCAFE_0004, 9, 32'h400, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hCAFE_0008, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h500 + 32'(k), 1'b0, 1'b0, 1'b0);
        send_frame(32'hCAFE_0007, 8, 32'h60, 1'b1, 1'b0, 1'b0);
        checkOutput("err_drop", 256'(drop_cnt), 256'd5);
        checkOutput("err_good", 256'(good_cnt), 256'd6);
        checkOutput("err_no_update", 256'(upd_cnt - upd_before), 256'd0);
        checkOutput("err_seq_kept", 256'(cfg_seq), 256'd3);

        // Drop counter saturation: each repeated frame_start drops one frame
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 249; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_254", 256'(drop_cnt), 256'd254);
        for (int k = 0; k < 51; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_255", 256'(drop_cnt), 256'd255);
        checkOutput("sat_idle", 256'(busy), 256'd0);

        // Asynchronous reset mid-payload
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hCAFE_000A, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h700 + 32'(k), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_cfg", cfg_data, 256'd0);
        checkOutput("arst_seq", 256'(cfg_seq), 256'd0);
        checkOutput("arst_pending", 256'(pending), 256'd0);
        checkOutput("arst_busy", 256'(busy), 256'd0);
        checkOutput("arst_good", 256'(good_cnt), 256'd0);
        checkOutput("arst_drop", 256'(drop_cnt), 256'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        send_frame(32'hCAFE_0009, 8, 32'h70, 1'b1, 1'b0, 1'b0);
        checkOutput("post_good", 256'(good_cnt), 256'd1);
        checkOutput("post_drop", 256'(drop_cnt), 256'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_update", 256'(cfg_update), 256'd1);
        checkOutput("post_seq", 256'(cfg_seq), 256'd9);
        checkOutput("post_cfg", cfg_data, exp_cfg(32'h70));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
